// File: rtl/pfa_frame_seq.sv
// pfa_frame_seq
//   Address sequencer for a three-factor prime-factor (Good/CRT) stage.
//   Once a start is accepted, it walks (n1, n2, n3) with n3 fastest. For
//   each index it emits (K1*n1 + K2*n2 + K3*n3) mod N, where
//   N = Nf1*Nf2*Nf3, K1 = Nf2*Nf3, K2 = Nf1*Nf3 and K3 = Nf1*Nf2.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   clr                   synchronous abort back to IDLE (beats dropped, no done)
//   start                 frame request, honoured only in IDLE
//   Nf1, Nf2, Nf3         factors, captured with an accepted start
//   busy                  high from LOAD through DONE
//   cfg_err               one-cycle pulse after a rejected start
//   out_valid/out_ready   beat handshake
//   out_addr              CRT-mapped buffer address
//   n1, n2, n3            index triple of the current beat
//   out_last              final beat of the frame
//   done                  one-cycle pulse after the final handshake
//   bank                  ping-pong select, toggles on each completed frame
module pfa_frame_seq #(
  parameter int wDataInOut = 16,
  parameter int wAddr      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  start,
  input  logic [wDataInOut-1:0] Nf1,
  input  logic [wDataInOut-1:0] Nf2,
  input  logic [wDataInOut-1:0] Nf3,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [wAddr-1:0]      out_addr,
  output logic [wDataInOut-1:0] n1,
  output logic [wDataInOut-1:0] n2,
  output logic [wDataInOut-1:0] n3,
  output logic                  out_last,
  output logic                  done,
  output logic                  bank
);

  // N can equal 2^wAddr, so it needs one extra bit. Every K and every
  // partial sum is strictly below N, so those fit in wAddr bits.
  localparam int wN = wAddr + 1;
  localparam int wP = 3 * wDataInOut;
  localparam logic [wP-1:0] N_MAX = wP'(1) << wAddr;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [wDataInOut-1:0] nf1_q, nf1_d, nf2_q, nf2_d, nf3_q, nf3_d;
  logic [wN-1:0]         n_q, n_d;
  logic [wAddr-1:0]      k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic [wAddr-1:0]      p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [wDataInOut-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic                  pend_q, pend_d;
  logic                  ov_q, ov_d;
  logic [wAddr-1:0]      addr_q, addr_d;
  logic [wDataInOut-1:0] o1_q, o1_d, o2_q, o2_d, o3_q, o3_d;
  logic                  last_q, last_d;
  logic                  bank_q, bank_d;
  logic                  cfg_err_q, cfg_err_d;

  // a + b mod n, given a, b < n.
  function automatic logic [wAddr-1:0] mod_add(input logic [wAddr-1:0] a,
                                               input logic [wAddr-1:0] b,
                                               input logic [wN-1:0]    n);
    logic [wN-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= n) s = s - n;
    return s[wAddr-1:0];
  endfunction

  // a + b + c mod n, given each term < n (so the sum is < 3n).
  function automatic logic [wAddr-1:0] mod_sum3(input logic [wAddr-1:0] a,
                                                input logic [wAddr-1:0] b,
                                                input logic [wAddr-1:0] c,
                                                input logic [wN-1:0]    n);
    logic [wAddr+1:0] s;
    logic [wAddr+1:0] nn;
    nn = {1'b0, n};
    s  = {2'b00, a} + {2'b00, b} + {2'b00, c};
    if (s >= nn) s = s - nn;
    if (s >= nn) s = s - nn;
    return s[wAddr-1:0];
  endfunction

  // Each K divides N and is therefore <= N; it equals N only when the
  // matching factor is 1, in which case K mod N is 0.
  function automatic logic [wAddr-1:0] reduce_k(input logic [wN-1:0] k,
                                                input logic [wN-1:0] n);
    return (k >= n) ? '0 : k[wAddr-1:0];
  endfunction

  logic [wP-1:0]    req_prod;
  logic             start_ok;
  logic [wN-1:0]    n_calc, k1_calc, k2_calc, k3_calc;
  logic             l1, l2, l3, load;
  logic [wAddr-1:0] beat_addr;

  // The full 3*wDataInOut-bit product cannot overflow.
  assign req_prod = wP'(Nf1) * wP'(Nf2) * wP'(Nf3);
  assign start_ok = (Nf1 != '0) && (Nf2 != '0) && (Nf3 != '0) && (req_prod <= N_MAX);

  // Accepted factors multiply to at most 2^wAddr, so these truncations are exact.
  assign n_calc  = wN'(nf1_q) * wN'(nf2_q) * wN'(nf3_q);
  assign k1_calc = wN'(nf2_q) * wN'(nf3_q);
  assign k2_calc = wN'(nf1_q) * wN'(nf3_q);
  assign k3_calc = wN'(nf1_q) * wN'(nf2_q);

  assign l1        = (i1_q == nf1_q - wDataInOut'(1));
  assign l2        = (i2_q == nf2_q - wDataInOut'(1));
  assign l3        = (i3_q == nf3_q - wDataInOut'(1));
  assign load      = !ov_q || out_ready;
  assign beat_addr = mod_sum3(p1_q, p2_q, p3_q, n_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      nf1_q     <= '0;  nf2_q <= '0;  nf3_q <= '0;
      n_q       <= '0;
      k1_q      <= '0;  k2_q  <= '0;  k3_q  <= '0;
      p1_q      <= '0;  p2_q  <= '0;  p3_q  <= '0;
      i1_q      <= '0;  i2_q  <= '0;  i3_q  <= '0;
      pend_q    <= 1'b0;
      ov_q      <= 1'b0;
      addr_q    <= '0;
      o1_q      <= '0;  o2_q  <= '0;  o3_q  <= '0;
      last_q    <= 1'b0;
      bank_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nf1_q     <= nf1_d;  nf2_q <= nf2_d;  nf3_q <= nf3_d;
      n_q       <= n_d;
      k1_q      <= k1_d;   k2_q  <= k2_d;   k3_q  <= k3_d;
      p1_q      <= p1_d;   p2_q  <= p2_d;   p3_q  <= p3_d;
      i1_q      <= i1_d;   i2_q  <= i2_d;   i3_q  <= i3_d;
      pend_q    <= pend_d;
      ov_q      <= ov_d;
      addr_q    <= addr_d;
      o1_q      <= o1_d;   o2_q  <= o2_d;   o3_q  <= o3_d;
      last_q    <= last_d;
      bank_q    <= bank_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    nf1_d     = nf1_q;  nf2_d = nf2_q;  nf3_d = nf3_q;
    n_d       = n_q;
    k1_d      = k1_q;   k2_d  = k2_q;   k3_d  = k3_q;
    p1_d      = p1_q;   p2_d  = p2_q;   p3_d  = p3_q;
    i1_d      = i1_q;   i2_d  = i2_q;   i3_d  = i3_q;
    pend_d    = pend_q;
    ov_d      = ov_q;
    addr_d    = addr_q;
    o1_d      = o1_q;   o2_d  = o2_q;   o3_d  = o3_q;
    last_d    = last_q;
    bank_d    = bank_q;
    cfg_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            nf1_d   = Nf1;
            nf2_d   = Nf2;
            nf3_d   = Nf3;
            state_d = S_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        n_d    = n_calc;
        k1_d   = reduce_k(k1_calc, n_calc);
        k2_d   = reduce_k(k2_calc, n_calc);
        k3_d   = reduce_k(k3_calc, n_calc);
        p1_d   = '0;  p2_d = '0;  p3_d = '0;
        i1_d   = '0;  i2_d = '0;  i3_d = '0;
        pend_d = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        // pend_q means index registers hold a beat not yet emitted.
        if (load) begin
          if (pend_q) begin
            ov_d   = 1'b1;
            addr_d = beat_addr;
            o1_d   = i1_q;
            o2_d   = i2_q;
            o3_d   = i3_q;
            last_d = l1 && l2 && l3;
            if (l1 && l2 && l3) begin
              pend_d = 1'b0;
            end else if (!l3) begin
              i3_d = i3_q + wDataInOut'(1);
              p3_d = mod_add(p3_q, k3_q, n_q);
            end else begin
              i3_d = '0;
              p3_d = '0;
              if (!l2) begin
                i2_d = i2_q + wDataInOut'(1);
                p2_d = mod_add(p2_q, k2_q, n_q);
              end else begin
                i2_d = '0;
                p2_d = '0;
                i1_d = i1_q + wDataInOut'(1);
                p1_d = mod_add(p1_q, k1_q, n_q);
              end
            end
          end else begin
            // Final beat has just been taken (or was never held).
            ov_d    = 1'b0;
            last_d  = 1'b0;
            bank_d  = ~bank_q;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a same-cycle start.
    if (clr) begin
      state_d   = S_IDLE;
      ov_d      = 1'b0;
      last_d    = 1'b0;
      pend_d    = 1'b0;
      bank_d    = bank_q;
      cfg_err_d = 1'b0;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign cfg_err   = cfg_err_q;
  assign out_valid = ov_q;
  assign out_addr  = addr_q;
  assign n1        = o1_q;
  assign n2        = o2_q;
  assign n3        = o3_q;
  assign out_last  = last_q;
  assign bank      = bank_q;

endmodule

// File: tb/tb_pfa_frame_seq.sv
module tb_pfa_frame_seq;
  localparam int W  = 16;
  localparam int A  = 12;
  localparam int AH = A + 3 * W;
  localparam int AL = 3 * W + 1;

  logic clk = 1'b0;
  logic rst, clr, start, out_ready;
  logic [W-1:0] Nf1, Nf2, Nf3;
  logic busy, cfg_err, out_valid, out_last, done, bank;
  logic [A-1:0] out_addr;
  logic [W-1:0] n1, n2, n3;

  pfa_frame_seq #(.wDataInOut(W), .wAddr(A)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start),
    .Nf1(Nf1), .Nf2(Nf2), .Nf3(Nf3),
    .busy(busy), .cfg_err(cfg_err), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .n1(n1), .n2(n2), .n3(n3),
    .out_last(out_last), .done(done), .bank(bank)
  );

  always #5 clk = ~clk;

  // beat = {addr, n1, n2, n3, last}
  typedef logic [AH:0] beat_t;
  beat_t got_q[$];
  beat_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int first_valid_cyc, last_beat_cyc, done_cyc, stable_err;
  logic exp_bank;

  // Reference: enumerate the index space directly and apply the CRT formula.
  task automatic build_model(input int f1, input int f2, input int f3);
    int nn, k1, k2, k3;
    nn = f1 * f2 * f3;  k1 = f2 * f3;  k2 = f1 * f3;  k3 = f1 * f2;
    exp_q.delete();
    for (int a = 0; a < f1; a++)
      for (int b = 0; b < f2; b++)
        for (int c = 0; c < f3; c++)
          exp_q.push_back({A'((k1 * a + k2 * b + k3 * c) % nn), W'(a), W'(b), W'(c),
                           (a == f1 - 1) && (b == f2 - 1) && (c == f3 - 1)});
  endtask

  task automatic start_frame(input int f1, input int f2, input int f3);
    @(negedge clk);
    Nf1 = W'(f1);  Nf2 = W'(f2);  Nf3 = W'(f3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives out_ready, records accepted beats, notes hold violations while
  // stalled. Returns at the done pulse or after stop_n beats; to=1 if neither.
  task automatic collect(input int max_cyc, input bit rnd, input int stop_n,
                         input int poke_cyc, output bit to);
    beat_t held_b;
    bit held, r;
    got_q.delete();
    first_valid_cyc = -1;  last_beat_cyc = -1;  done_cyc = -1;
    stable_err = 0;  held = 1'b0;  to = 1'b1;  held_b = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      if (cyc == poke_cyc) begin
        Nf1 = W'(2);  Nf2 = W'(2);  Nf3 = W'(2);  start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;  to = 1'b0;
        break;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (held && (out_valid !== 1'b1 || {out_addr, n1, n2, n3, out_last} !== held_b))
        stable_err++;
      held = 1'b0;
      if (out_valid === 1'b1) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (r) begin
          got_q.push_back({out_addr, n1, n2, n3, out_last});
          last_beat_cyc = cyc;
          if (stop_n > 0 && got_q.size() == stop_n) begin
            to = 1'b0;
            break;
          end
        end else begin
          held = 1'b1;
          held_b = {out_addr, n1, n2, n3, out_last};
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;  clr = 1'b0;  start = 1'b0;  out_ready = 1'b0;
    Nf1 = '0;  Nf2 = '0;  Nf3 = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({out_valid, busy, done, bank, cfg_err, out_last} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b exp 000000", {out_valid, busy, done, bank, cfg_err, out_last});
    end
    vectors++;
    if ({out_addr, n1, n2, n3} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got %h exp 0", {out_addr, n1, n2, n3});
    end
    rst = 1'b0;
    exp_bank = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle busy got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    bit to;
    bit seen[60];
    int dup;
    beat_t b;
    build_model(4, 5, 3);
    start_frame(4, 5, 3);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_load got %b exp 1", busy); end
    collect(200, 1'b0, 0, -1, to);
    exp_bank = ~exp_bank;
    vectors++;
    if (to) begin miscompares++; $display("FAIL basic_timeout got no done exp done"); end
    vectors++;
    if (got_q.size() != 60) begin miscompares++; $display("FAIL basic_count got %0d exp 60", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL basic_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (first_valid_cyc != 1) begin miscompares++; $display("FAIL basic_latency got %0d exp 1", first_valid_cyc); end
    vectors++;
    if (last_beat_cyc - first_valid_cyc != 59) begin
      miscompares++;
      $display("FAIL basic_consecutive got span %0d exp 59", last_beat_cyc - first_valid_cyc);
    end
    vectors++;
    if (done_cyc != last_beat_cyc + 1) begin
      miscompares++;
      $display("FAIL basic_done_timing got %0d exp %0d", done_cyc, last_beat_cyc + 1);
    end
    if (got_q.size() == 60) begin
      b = got_q[15];
      vectors++;
      if (b[AH:AL] !== 12'd15) begin miscompares++; $display("FAIL basic_beat100 got %0d exp 15", b[AH:AL]); end
      b = got_q[59];
      vectors++;
      if (b !== {12'd13, 16'd3, 16'd4, 16'd2, 1'b1}) begin
        miscompares++;
        $display("FAIL basic_final got %h exp addr 13 n 3,4,2 last", b);
      end
    end
    for (int i = 0; i < 60; i++) seen[i] = 1'b0;
    dup = 0;
    foreach (got_q[i]) begin
      int ad;
      b = got_q[i];
      ad = int'(b[AH:AL]);
      if (ad >= 60 || seen[ad]) dup++;
      else seen[ad] = 1'b1;
    end
    vectors++;
    if (dup != 0) begin miscompares++; $display("FAIL basic_permutation got %0d bad addresses exp 0", dup); end
    @(negedge clk);
    vectors++;
    if ({done, busy} !== 2'b00) begin miscompares++; $display("FAIL basic_done_pulse got %b exp 00", {done, busy}); end
    vectors++;
    if (bank !== exp_bank) begin miscompares++; $display("FAIL basic_bank got %b exp %b", bank, exp_bank); end
    $display("frame 4x5x3 ready=1 beats=%0d bank=%b", got_q.size(), bank);
  endtask

  task automatic test_stall();
    bit to;
    build_model(4, 5, 3);
    start_frame(4, 5, 3);
    collect(600, 1'b1, 0, -1, to);
    exp_bank = ~exp_bank;
    vectors++;
    if (to) begin miscompares++; $display("FAIL stall_timeout got no done exp done"); end
    vectors++;
    if (got_q.size() != 60) begin miscompares++; $display("FAIL stall_count got %0d exp 60", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL stall_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (stable_err != 0) begin miscompares++; $display("FAIL stall_hold got %0d changes exp 0", stable_err); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL stall_single_done got %b exp 0", done); end
    vectors++;
    if (bank !== exp_bank) begin miscompares++; $display("FAIL stall_bank got %b exp %b", bank, exp_bank); end
    $display("frame 4x5x3 ready=random beats=%0d bank=%b", got_q.size(), bank);
  endtask

  task automatic test_unity();
    bit to;
    build_model(1, 1, 1);
    start_frame(1, 1, 1);
    collect(50, 1'b0, 0, -1, to);
    exp_bank = ~exp_bank;
    vectors++;
    if (to || got_q.size() != 1) begin
      miscompares++;
      $display("FAIL unity_count got %0d beats timeout=%b exp 1", got_q.size(), to);
    end
    if (got_q.size() == 1) begin
      vectors++;
      if (got_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL unity_beat got %h exp %h", got_q[0], exp_q[0]); end
    end
    @(negedge clk);
    vectors++;
    if (bank !== exp_bank) begin miscompares++; $display("FAIL unity_bank got %b exp %b", bank, exp_bank); end
    $display("frame 1x1x1 beats=%0d bank=%b", got_q.size(), bank);
  endtask

  task automatic test_cfg_err();
    bit to;
    int bad;
    start_frame(4, 0, 3);
    vectors++;
    if ({cfg_err, busy} !== 2'b10) begin miscompares++; $display("FAIL cfg_zero got %b exp 10", {cfg_err, busy}); end
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if ({cfg_err, busy, out_valid} !== 3'b000) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL cfg_zero_after got %0d bad cycles exp 0", bad); end
    start_frame(17, 16, 16);
    vectors++;
    if ({cfg_err, busy} !== 2'b10) begin miscompares++; $display("FAIL cfg_toobig got %b exp 10", {cfg_err, busy}); end
    $display("rejected starts 4x0x3 and 17x16x16");
    build_model(16, 16, 16);
    start_frame(16, 16, 16);
    vectors++;
    if ({cfg_err, busy} !== 2'b01) begin miscompares++; $display("FAIL cfg_max_accept got %b exp 01", {cfg_err, busy}); end
    collect(5000, 1'b0, 0, -1, to);
    exp_bank = ~exp_bank;
    vectors++;
    if (to || got_q.size() != 4096) begin
      miscompares++;
      $display("FAIL max_count got %0d beats timeout=%b exp 4096", got_q.size(), to);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL max_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    $display("frame 16x16x16 beats=%0d", got_q.size());
  endtask

  task automatic test_clr();
    bit to;
    int dn;
    build_model(8, 9, 7);
    start_frame(8, 9, 7);
    collect(400, 1'b0, 100, -1, to);
    vectors++;
    if (to || got_q.size() != 100) begin
      miscompares++;
      $display("FAIL clr_prefix_count got %0d timeout=%b exp 100", got_q.size(), to);
    end
    foreach (got_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL clr_prefix[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vectors++;
    if ({out_valid, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL clr_idle got %b exp 000", {out_valid, busy, done});
    end
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0 || out_valid !== 1'b0) dn++;
    end
    vectors++;
    if (dn != 0) begin miscompares++; $display("FAIL clr_no_done got %0d cycles exp 0", dn); end
    vectors++;
    if (bank !== exp_bank) begin miscompares++; $display("FAIL clr_bank got %b exp %b", bank, exp_bank); end
    $display("frame 8x9x7 aborted after %0d beats", got_q.size());
    // clr and start in the same cycle: start dropped
    @(negedge clk);
    Nf1 = W'(4);  Nf2 = W'(5);  Nf3 = W'(3);
    start = 1'b1;  clr = 1'b1;
    @(negedge clk);
    start = 1'b0;  clr = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL clr_start_same got busy %b exp 0", busy); end
    build_model(4, 5, 3);
    start_frame(4, 5, 3);
    collect(600, 1'b1, 0, -1, to);
    exp_bank = ~exp_bank;
    vectors++;
    if (to || got_q.size() != 60) begin
      miscompares++;
      $display("FAIL restart_count got %0d timeout=%b exp 60", got_q.size(), to);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL restart_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if (bank !== exp_bank) begin miscompares++; $display("FAIL restart_bank got %b exp %b", bank, exp_bank); end
    $display("frame 4x5x3 restart beats=%0d bank=%b", got_q.size(), bank);
  endtask

  task automatic test_start_ignored();
    bit to;
    build_model(4, 5, 3);
    start_frame(4, 5, 3);
    collect(200, 1'b0, 0, 10, to);
    exp_bank = ~exp_bank;
    vectors++;
    if (to || got_q.size() != 60) begin
      miscompares++;
      $display("FAIL ignore_count got %0d timeout=%b exp 60", got_q.size(), to);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL ignore_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if ({busy, bank} !== {1'b0, exp_bank}) begin
      miscompares++;
      $display("FAIL ignore_after got %b exp %b", {busy, bank}, {1'b0, exp_bank});
    end
    $display("frame 4x5x3 with start during RUN beats=%0d", got_q.size());
  endtask

  task automatic test_back_to_back();
    bit to;
    int f1, f2, f3;
    for (int fr = 0; fr < 3; fr++) begin
      f1 = int'($urandom_range(1, 5));
      f2 = int'($urandom_range(1, 5));
      f3 = int'($urandom_range(1, 5));
      build_model(f1, f2, f3);
      start_frame(f1, f2, f3);
      collect(1000, 1'b1, 0, -1, to);
      exp_bank = ~exp_bank;
      vectors++;
      if (to || got_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL b2b%0d_count got %0d timeout=%b exp %0d", fr, got_q.size(), to, exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL b2b%0d_beat[%0d] got %h exp %h", fr, i, got_q[i], exp_q[i]);
        end
      end
      vectors++;
      if (bank !== exp_bank) begin miscompares++; $display("FAIL b2b%0d_bank got %b exp %b", fr, bank, exp_bank); end
      $display("frame %0dx%0dx%0d back-to-back beats=%0d bank=%b", f1, f2, f3, got_q.size(), bank);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    start_frame(8, 9, 7);
    collect(400, 1'b0, 20, -1, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL rstmid_prefix got timeout exp 20 beats"); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, busy, done, bank, cfg_err, out_last, out_addr, n1, n2, n3} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async got %h exp 0",
               {out_valid, busy, done, bank, cfg_err, out_last, out_addr, n1, n2, n3});
    end
    @(negedge clk);
    rst = 1'b0;
    exp_bank = 1'b0;
    build_model(1, 1, 1);
    start_frame(1, 1, 1);
    collect(50, 1'b0, 0, -1, to);
    exp_bank = ~exp_bank;
    vectors++;
    if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      miscompares++;
      $display("FAIL rstmid_recover got %0d beats timeout=%b exp 1 beat", got_q.size(), to);
    end
    @(negedge clk);
    vectors++;
    if (bank !== exp_bank) begin miscompares++; $display("FAIL rstmid_bank got %b exp %b", bank, exp_bank); end
    $display("reset mid-frame then 1x1x1 frame bank=%b", bank);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_unity();
    test_cfg_err();
    test_clr();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
